modulo_initiator: RTL and testbench

Request-side controller for the `modulo_top` core. It accepts operand pairs from an upstream valid/ready stream and buffers them in a small FIFO. It issues them one at a time to the core over the core's `start`/`valid` interface and returns each remainder downstream with an error code. It sits between the system datapath and `modulo_top` and replaces the hand-driven `start_i`/`Zahl1`/`Zahl2` stimulus used today.

---
 rtl/modulo_initiator.sv | 143 ++++++++++++++
 tb/tb_modulo_initiator.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_initiator.sv
// Request-side controller for the modulo core: buffers operand pairs in a FIFO,
// issues them one at a time over start/valid and returns remainder plus error code.
module modulo_initiator #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             start_o,
  output logic [WIDTH-1:0] Zahl1_o,
  output logic [WIDTH-1:0] Zahl2_o,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] ergebnis_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic [1:0]       err_o,
  output logic             busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] mem_a [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;

  logic             stage_valid;
  logic [WIDTH-1:0] stage_a, stage_b;
  logic [TMR_W-1:0] timer;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign op_ready_o = !full;
  assign push       = op_valid_i && !full;
  // The popped head waits one cycle in the stage register before the divisor is judged.
  assign pop        = (state == IDLE) && !stage_valid && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= op_a_i;
      mem_b[wr_ptr] <= op_b_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_a     <= '0;
      stage_b     <= '0;
    end else if (pop) begin
      stage_valid <= 1'b1;
      stage_a     <= mem_a[rd_ptr];
      stage_b     <= mem_b[rd_ptr];
    end else if (state == IDLE) begin
      stage_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (stage_valid) state_d = (stage_b == '0) ? HOLD : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (valid_i || timer == TMR_W'(TIMEOUT)) state_d = HOLD;
      HOLD:    if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result valid_i wins over the timeout when both occur on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Zahl1_o <= '0;
      Zahl2_o <= '0;
      res_o   <= '0;
      err_o   <= 2'b00;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stage_valid) begin
            if (stage_b == '0) begin
              res_o <= '0;
              err_o <= 2'b01;
            end else begin
              Zahl1_o <= stage_a;
              Zahl2_o <= stage_b;
            end
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (valid_i) begin
            res_o <= ergebnis_i;
            err_o <= 2'b00;
          end else if (timer == TMR_W'(TIMEOUT)) begin
            res_o <= '0;
            err_o <= 2'b10;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign start_o     = (state == ISSUE);
  assign res_valid_o = (state == HOLD);
  assign busy_o      = (state != IDLE) || !empty || stage_valid;

endmodule

// File: tb/tb_modulo_initiator.sv
// Scoreboard bench for modulo_initiator with a behavioural core stub that answers
// a % b after a random delay, or stays silent to force timeouts.
module tb_modulo_initiator;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic             op_ready_o;
  logic [WIDTH-1:0] op_a, op_b;
  logic             start_o;
  logic [WIDTH-1:0] Zahl1_o, Zahl2_o;
  logic             valid_i;
  logic [WIDTH-1:0] ergebnis_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] res_o;
  logic [1:0]       err_o;
  logic             busy_o;

  logic fixed_ready;
  logic rnd_ready;
  bit   rand_ready;
  bit   core_silent;

  int checks   = 0;
  int failures = 0;
  int start_count = 0;
  int exp_starts  = 0;

  logic [WIDTH+1:0]   exp_res_q[$];
  logic [2*WIDTH-1:0] exp_issue_q[$];

  assign res_ready_i = rand_ready ? rnd_ready : fixed_ready;

  modulo_initiator #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid), .op_ready_o(op_ready_o), .op_a_i(op_a), .op_b_i(op_b),
    .start_o(start_o), .Zahl1_o(Zahl1_o), .Zahl2_o(Zahl2_o),
    .valid_i(valid_i), .ergebnis_i(ergebnis_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: remainder of a by b, zero divisor and silent core map to error codes.
  function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input bit silent);
    if (b == '0) return {{WIDTH{1'b0}}, 2'b01};
    if (silent)  return {{WIDTH{1'b0}}, 2'b10};
    return {a % b, 2'b00};
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit accepted = 0;
    bit rdy;
    int waited = 0;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    while (!accepted && waited < 2000) begin
      @(negedge clk);
      rdy = op_ready_o;
      @(posedge clk);
      #1;
      if (rdy) accepted = 1;
      else waited++;
    end
    op_valid = 1'b0;
    if (!accepted) begin
      checkOutput("push_accept_timeout", 0, 1);
    end else begin
      exp_res_q.push_back(refModel(a, b, core_silent));
      if (b != '0) begin
        exp_issue_q.push_back({a, b});
        exp_starts++;
      end
    end
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (!(busy_o == 1'b0 && exp_res_q.size() == 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= limit) checkOutput("idle_timeout", 0, 1);
  endtask

  // Result monitor: each handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && res_valid_o && res_ready_i) begin
      if (exp_res_q.size() == 0) checkOutput("unexpected_result", 1, 0);
      else checkOutput("result", {res_o, err_o}, exp_res_q.pop_front());
    end
  end

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Core stub: sees start_o, checks issued operands, answers after a random delay.
  initial begin
    logic [2*WIDTH-1:0] cur_ops;
    bit core_active;
    int core_delay;
    cur_ops = '0;
    core_active = 0;
    core_delay = 0;
    valid_i = 1'b0;
    ergebnis_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && start_o) begin
        start_count++;
        if (exp_issue_q.size() == 0) begin
          checkOutput("unexpected_start", 1, 0);
        end else begin
          cur_ops = exp_issue_q.pop_front();
          checkOutput("issue_operands", {Zahl1_o, Zahl2_o}, cur_ops);
        end
        if (!core_silent) begin
          core_active = 1;
          core_delay = $urandom_range(0, 8);
        end
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      if (rst) begin
        core_active = 0;
      end else if (core_active) begin
        if (core_delay == 0) begin
          checkOutput("operands_held", {Zahl1_o, Zahl2_o}, cur_ops);
          ergebnis_i = (Zahl2_o != '0) ? Zahl1_o % Zahl2_o : '0;
          valid_i = 1'b1;
          core_active = 0;
        end else begin
          core_delay--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    logic [WIDTH-1:0] a, b;
    rst = 1'b1;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    fixed_ready = 1'b1;
    rand_ready = 0;
    core_silent = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_op_ready", op_ready_o, 1);
    checkOutput("reset_start", start_o, 0);
    checkOutput("reset_res_valid", res_valid_o, 0);
    checkOutput("reset_res", res_o, 0);
    checkOutput("reset_err", err_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_zahl", {Zahl1_o, Zahl2_o}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic request and issue latency
    s0 = start_count;
    applyStimulus(16'd400, 16'd20);
    checkOutput("busy_after_push", busy_o, 1);
    @(posedge clk); #1;
    checkOutput("issue_latency_e1", start_o, 0);
    @(posedge clk); #1;
    checkOutput("issue_latency_e2", start_o, 1);
    waitIdle(500);
    checkOutput("basic_start_pulses", start_count - s0, 1);

    // Back-to-back requests
    s0 = start_count;
    applyStimulus(16'd9540, 16'd5175);
    applyStimulus(16'd400, 16'd21);
    waitIdle(500);
    checkOutput("b2b_start_pulses", start_count - s0, 2);

    // Zero divisor
    s0 = start_count;
    applyStimulus(16'd7, 16'd0);
    @(posedge clk); #1;
    checkOutput("zero_div_e1", res_valid_o, 0);
    @(posedge clk); #1;
    checkOutput("zero_div_e2", res_valid_o, 1);
    checkOutput("zero_div_err", err_o, 1);
    waitIdle(500);
    checkOutput("zero_div_no_start", start_count - s0, 0);

    // FIFO full under back-pressure
    fixed_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(WIDTH'($urandom), WIDTH'($urandom_range(1, 300)));
    @(negedge clk);
    checkOutput("fifo_full_ready", op_ready_o, 0);
    fork
      applyStimulus(16'd1234, 16'd11);
      begin
        repeat (20) @(posedge clk);
        #1;
        checkOutput("sixth_held", op_ready_o, 0);
        checkOutput("hold_res_valid", res_valid_o, 1);
        fixed_ready = 1'b1;
      end
    join
    waitIdle(1000);

    // Timeout against a silent core
    core_silent = 1;
    applyStimulus(16'd100, 16'd7);
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk); #1;
      if (k == 18) checkOutput("timeout_e18", res_valid_o, 0);
      if (k == 19) checkOutput("timeout_e19", res_valid_o, 1);
    end
    checkOutput("timeout_err", err_o, 2);
    waitIdle(500);
    checkOutput("timeout_idle_busy", busy_o, 0);

    // Reset during WAIT with two pairs queued
    applyStimulus(16'd50, 16'd3);
    applyStimulus(16'd60, 16'd7);
    applyStimulus(16'd70, 16'd9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_starts -= exp_issue_q.size();
    exp_issue_q.delete();
    exp_res_q.delete();
    #1;
    checkOutput("midrst_op_ready", op_ready_o, 1);
    checkOutput("midrst_start", start_o, 0);
    checkOutput("midrst_res_valid", res_valid_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_zahl", {Zahl1_o, Zahl2_o}, 0);
    checkOutput("midrst_res_err", {res_o, err_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    core_silent = 0;
    repeat (25) @(posedge clk);
    #1;
    checkOutput("midrst_no_result", res_valid_o, 0);
    checkOutput("midrst_busy_after", busy_o, 0);
    applyStimulus(16'd10, 16'd3);
    waitIdle(500);

    // Randomized traffic with random downstream back-pressure
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = WIDTH'($urandom_range(1, 20));
        default: b = WIDTH'($urandom);
      endcase
      applyStimulus(a, b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    waitIdle(3000);
    rand_ready = 0;

    checkOutput("total_start_pulses", start_count, exp_starts);
    checkOutput("scoreboard_empty", exp_res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
